// File: rtl/ssit_pkg.sv
// Shared types for the store set ID table.
// SSID width default, trainer states, SSID merge helper.
package ssit_pkg;

    localparam int SSID_W_DEF = 7;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE
    } trn_state_e;

    // Store sets merge toward the lower ID so that
    // both sides of a conflict converge on one set.
    function automatic logic [31:0] ssid_min(
        input logic [31:0] a,
        input logic [31:0] b
    );
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/ssit_index.sv
// PC to table index, shared by lookup and training.
// Ports: pc (in), idx (out). Macro SSIT_PC_HASH_EN folds upper PC bits.
module ssit_index #(
    parameter int IDX_W = 10,
    parameter int PC_W  = 64
) (
    input  logic [PC_W-1:0]  pc,
    output logic [IDX_W-1:0] idx
);

`ifdef SSIT_PC_HASH_EN
    assign idx = pc[IDX_W+1:2] ^ pc[2*IDX_W+1:IDX_W+2];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc[PC_W-1:2*IDX_W+2], pc[1:0]};
`else
    assign idx = pc[IDX_W+1:2];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc[PC_W-1:IDX_W+2], pc[1:0]};
`endif

endmodule

// File: rtl/ssit.sv
// Store Set ID Table: 4-wide PC->SSID lookup, violation trainer,
// periodic invalidation. Ports: clock, reset_n, stall_in, pc/lookup_valid
// 0-3 in, ssid/ssid_valid 0-3 out, viol_* handshake, clear_pulse_out.
// Optional macro SSIT_PC_HASH_EN selects the hashed index (ssit_index).
module ssit
    import ssit_pkg::*;
#(
    parameter int IDX_W        = 10,
    parameter int SSID_W       = SSID_W_DEF,
    parameter int PC_W         = 64,
    parameter int CLEAR_PERIOD = 100000
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              stall_in,
    input  logic [PC_W-1:0]   pc0_in,
    input  logic [PC_W-1:0]   pc1_in,
    input  logic [PC_W-1:0]   pc2_in,
    input  logic [PC_W-1:0]   pc3_in,
    input  logic              lookup_valid0_in,
    input  logic              lookup_valid1_in,
    input  logic              lookup_valid2_in,
    input  logic              lookup_valid3_in,
    output logic [SSID_W-1:0] ssid0_out,
    output logic [SSID_W-1:0] ssid1_out,
    output logic [SSID_W-1:0] ssid2_out,
    output logic [SSID_W-1:0] ssid3_out,
    output logic              ssid_valid0_out,
    output logic              ssid_valid1_out,
    output logic              ssid_valid2_out,
    output logic              ssid_valid3_out,
    input  logic              viol_valid_in,
    output logic              viol_ready_out,
    input  logic [PC_W-1:0]   viol_ld_pc_in,
    input  logic [PC_W-1:0]   viol_st_pc_in,
    output logic              clear_pulse_out
);

    localparam int ENTRIES = 2**IDX_W;
    localparam int CNT_W   = $clog2(CLEAR_PERIOD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLEAR_PERIOD - 1);

    // Table storage
    logic [SSID_W-1:0] ssid_f [ENTRIES];
    logic [ENTRIES-1:0] v_f;

    // Index generation
    logic [PC_W-1:0]  lk_pc  [4];
    logic [3:0]       lk_v;
    logic [IDX_W-1:0] lk_idx [4];
    logic [IDX_W-1:0] ld_idx_c;
    logic [IDX_W-1:0] st_idx_c;

    assign lk_pc[0] = pc0_in;
    assign lk_pc[1] = pc1_in;
    assign lk_pc[2] = pc2_in;
    assign lk_pc[3] = pc3_in;
    assign lk_v = {lookup_valid3_in, lookup_valid2_in,
                   lookup_valid1_in, lookup_valid0_in};

    for (genvar g = 0; g < 4; g++) begin : g_lk
        ssit_index #(.IDX_W(IDX_W), .PC_W(PC_W)) u_idx (
            .pc  (lk_pc[g]),
            .idx (lk_idx[g])
        );
    end

    ssit_index #(.IDX_W(IDX_W), .PC_W(PC_W)) u_ld_idx (
        .pc  (viol_ld_pc_in),
        .idx (ld_idx_c)
    );

    ssit_index #(.IDX_W(IDX_W), .PC_W(PC_W)) u_st_idx (
        .pc  (viol_st_pc_in),
        .idx (st_idx_c)
    );

    // Periodic clear
    logic [CNT_W-1:0] per_f;
    logic             clear;

    assign clear           = (per_f == CNT_LAST);
    assign clear_pulse_out = clear;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) per_f <= '0;
        else          per_f <= clear ? '0 : per_f + 1'b1;
    end

    // Lookup output registers
    logic [SSID_W-1:0] ssid_q [4];
    logic [3:0]        sv_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < 4; s++) ssid_q[s] <= '0;
            sv_q <= '0;
        end else if (!stall_in) begin
            for (int s = 0; s < 4; s++) begin
                ssid_q[s] <= ssid_f[lk_idx[s]];
                sv_q[s]   <= v_f[lk_idx[s]] & lk_v[s];
            end
        end
    end

    assign ssid0_out       = ssid_q[0];
    assign ssid1_out       = ssid_q[1];
    assign ssid2_out       = ssid_q[2];
    assign ssid3_out       = ssid_q[3];
    assign ssid_valid0_out = sv_q[0];
    assign ssid_valid1_out = sv_q[1];
    assign ssid_valid2_out = sv_q[2];
    assign ssid_valid3_out = sv_q[3];

    // Trainer
    trn_state_e        state_f;
    trn_state_e        state_n;
    logic [IDX_W-1:0]  ld_idx_f;
    logic [IDX_W-1:0]  st_idx_f;
    logic              ld_v_f;
    logic              st_v_f;
    logic [SSID_W-1:0] ld_ssid_f;
    logic [SSID_W-1:0] st_ssid_f;
    logic [SSID_W-1:0] alloc_f;
    logic              lat_idx;
    logic              lat_ent;
    logic              wr_en;
    logic              use_alloc;
    logic [SSID_W-1:0] new_ssid;
    logic [31:0]       min_ssid;

    always_comb begin
        state_n        = state_f;
        viol_ready_out = 1'b0;
        lat_idx        = 1'b0;
        lat_ent        = 1'b0;
        wr_en          = 1'b0;
        unique case (state_f)
            IDLE: begin
                viol_ready_out = 1'b1;
                if (viol_valid_in) begin
                    lat_idx = 1'b1;
                    state_n = READ;
                end
            end
            READ: begin
                lat_ent = 1'b1;
                state_n = WRITE;
            end
            WRITE: begin
                // A coincident clear wins; the report is dropped.
                wr_en   = ~clear;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign min_ssid = ssid_min(32'(ld_ssid_f), 32'(st_ssid_f));

    always_comb begin
        new_ssid  = alloc_f;
        use_alloc = 1'b0;
        unique case (1'b1)
            ~ld_v_f & ~st_v_f: use_alloc = 1'b1;
            ld_v_f & ~st_v_f:  new_ssid  = ld_ssid_f;
            ~ld_v_f & st_v_f:  new_ssid  = st_ssid_f;
            default:           new_ssid  = min_ssid[SSID_W-1:0];
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_f   <= IDLE;
            ld_idx_f  <= '0;
            st_idx_f  <= '0;
            ld_v_f    <= 1'b0;
            st_v_f    <= 1'b0;
            ld_ssid_f <= '0;
            st_ssid_f <= '0;
            alloc_f   <= '0;
        end else begin
            state_f <= state_n;
            if (lat_idx) begin
                ld_idx_f <= ld_idx_c;
                st_idx_f <= st_idx_c;
            end
            // Entries read during a clear are seen as invalid.
            if (lat_ent) begin
                ld_v_f    <= v_f[ld_idx_f] & ~clear;
                st_v_f    <= v_f[st_idx_f] & ~clear;
                ld_ssid_f <= ssid_f[ld_idx_f];
                st_ssid_f <= ssid_f[st_idx_f];
            end
            if (wr_en && use_alloc) alloc_f <= alloc_f + 1'b1;
        end
    end

    // Table update; same-index pairs collapse to one write.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            v_f <= '0;
            for (int i = 0; i < ENTRIES; i++) ssid_f[i] <= '0;
        end else if (clear) begin
            v_f <= '0;
        end else if (wr_en) begin
            v_f[ld_idx_f]    <= 1'b1;
            v_f[st_idx_f]    <= 1'b1;
            ssid_f[ld_idx_f] <= new_ssid;
            ssid_f[st_idx_f] <= new_ssid;
        end
    end

endmodule

// File: tb/tb_ssit.sv
// Self-checking bench for ssit: directed store-set scenarios
// plus randomized traffic against a behavioural table model.
module tb_ssit;

    localparam int P      = 256;
    localparam int SSID_W = 7;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall_in = 1'b0;
    logic [63:0] pcs [4];
    logic [3:0]  lvs = '0;
    logic        viol_valid = 1'b0;
    logic [63:0] ld_pc = '0;
    logic [63:0] st_pc = '0;
    logic        viol_ready_out;
    logic        clear_pulse_out;
    logic [6:0]  d_ssid [4];
    logic [3:0]  d_sv;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    always #5 clock = ~clock;

    ssit #(.IDX_W(10), .SSID_W(7), .PC_W(64), .CLEAR_PERIOD(P)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .stall_in         (stall_in),
        .pc0_in           (pcs[0]),
        .pc1_in           (pcs[1]),
        .pc2_in           (pcs[2]),
        .pc3_in           (pcs[3]),
        .lookup_valid0_in (lvs[0]),
        .lookup_valid1_in (lvs[1]),
        .lookup_valid2_in (lvs[2]),
        .lookup_valid3_in (lvs[3]),
        .ssid0_out        (d_ssid[0]),
        .ssid1_out        (d_ssid[1]),
        .ssid2_out        (d_ssid[2]),
        .ssid3_out        (d_ssid[3]),
        .ssid_valid0_out  (d_sv[0]),
        .ssid_valid1_out  (d_sv[1]),
        .ssid_valid2_out  (d_sv[2]),
        .ssid_valid3_out  (d_sv[3]),
        .viol_valid_in    (viol_valid),
        .viol_ready_out   (viol_ready_out),
        .viol_ld_pc_in    (ld_pc),
        .viol_st_pc_in    (st_pc),
        .clear_pulse_out  (clear_pulse_out)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] idx_of(input logic [63:0] pc);
`ifdef SSIT_PC_HASH_EN
        return pc[11:2] ^ pc[21:12];
`else
        return pc[11:2];
`endif
    endfunction

    // Behavioural model: table as plain arrays, a report as a
    // pending job that reads one cycle after acceptance and
    // writes the cycle after that.
    logic [1023:0] m_v;
    logic [1023:0] m_known;
    logic [6:0]    m_ssid [1024];
    logic [6:0]    m_alloc;
    int            m_per;
    int            m_phase;
    logic [9:0]    r_ld, r_st;
    logic          r_lv, r_sv;
    logic [6:0]    r_lssid, r_sssid;
    logic [6:0]    e_ssid [4];
    logic [3:0]    e_sv;
    logic [3:0]    e_known;
    logic          m_clr;
    logic [6:0]    m_new;

    // Merged set = lowest valid SSID of the pair, else a fresh one.
    function automatic logic [6:0] merge(input logic lv, input logic sv,
        input logic [6:0] ls, input logic [6:0] ss, input logic [6:0] al);
        int best = 1 << SSID_W;
        if (lv) best = int'(ls);
        if (sv && int'(ss) < best) best = int'(ss);
        return (best == (1 << SSID_W)) ? al : best[6:0];
    endfunction

    assign m_clr = (m_per == P - 1);
    assign m_new = merge(r_lv, r_sv, r_lssid, r_sssid, m_alloc);

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_v     <= '0;
            m_known <= '0;
            m_alloc <= '0;
            m_per   <= 0;
            m_phase <= 0;
            e_sv    <= '0;
            e_known <= '0;
            for (int s = 0; s < 4; s++) e_ssid[s] <= '0;
        end else begin
            if (!stall_in) begin
                for (int s = 0; s < 4; s++) begin
                    e_sv[s]    <= m_v[idx_of(pcs[s])] & lvs[s];
                    e_ssid[s]  <= m_ssid[idx_of(pcs[s])];
                    e_known[s] <= m_known[idx_of(pcs[s])];
                end
            end
            if (m_phase == 0) begin
                if (viol_valid) begin
                    r_ld    <= idx_of(ld_pc);
                    r_st    <= idx_of(st_pc);
                    m_phase <= 1;
                end
            end else if (m_phase == 1) begin
                r_lv    <= m_v[r_ld] & ~m_clr;
                r_sv    <= m_v[r_st] & ~m_clr;
                r_lssid <= m_ssid[r_ld];
                r_sssid <= m_ssid[r_st];
                m_phase <= 2;
            end else begin
                if (!m_clr) begin
                    m_v[r_ld]     <= 1'b1;
                    m_v[r_st]     <= 1'b1;
                    m_known[r_ld] <= 1'b1;
                    m_known[r_st] <= 1'b1;
                    m_ssid[r_ld]  <= m_new;
                    m_ssid[r_st]  <= m_new;
                    if (!r_lv && !r_sv) m_alloc <= m_alloc + 7'd1;
                end
                m_phase <= 0;
            end
            if (m_clr) m_v <= '0;
            m_per <= m_clr ? 0 : m_per + 1;
        end
    end

    // Compare process
    always @(negedge clock) begin
        if (started) begin
            for (int s = 0; s < 4; s++) begin
                chk($sformatf("sv%0d", s), 64'(d_sv[s]), 64'(e_sv[s]));
                if (e_known[s])
                    chk($sformatf("ssid%0d", s), 64'(d_ssid[s]),
                        64'(e_ssid[s]));
            end
            chk("ready", 64'(viol_ready_out), 64'(m_phase == 0));
            chk("clear", 64'(clear_pulse_out), 64'(m_clr));
        end
    end

    task automatic report(input logic [63:0] ld, input logic [63:0] st);
        int n = 0;
        while (!viol_ready_out && n < 10) begin
            @(negedge clock);
            n++;
        end
        if (n >= 10) chk("ready_timeout", 64'(viol_ready_out), 64'd1);
        ld_pc = ld;
        st_pc = st;
        viol_valid = 1'b1;
        @(negedge clock);
        viol_valid = 1'b0;
        chk("busy_read", 64'(viol_ready_out), 64'd0);
        @(negedge clock);
        chk("busy_write", 64'(viol_ready_out), 64'd0);
        @(negedge clock);
        chk("ready_back", 64'(viol_ready_out), 64'd1);
    endtask

    task automatic lookup(input logic [63:0] pc, output logic [6:0] id,
                          output logic v);
        stall_in = 1'b0;
        pcs[0] = pc;
        lvs[0] = 1'b1;
        @(negedge clock);
        id = d_ssid[0];
        v  = d_sv[0];
    endtask

    task automatic expect_lk(input string name, input logic [63:0] pc,
                             input logic ev, input logic [6:0] eid);
        logic [6:0] id;
        logic       v;
        lookup(pc, id, v);
        chk({name, "_v"}, 64'(v), 64'(ev));
        if (ev) chk({name, "_id"}, 64'(id), 64'(eid));
    endtask

    task automatic avoid_clear(input int margin);
        int n = 0;
        while (m_per > P - margin && n < P + 4) begin
            @(negedge clock);
            n++;
        end
    endtask

    initial begin
        logic [6:0] id;
        logic       v;
        int         n;
        for (int s = 0; s < 4; s++) pcs[s] = '0;
        repeat (3) @(negedge clock);
        started = 1'b1;
        @(negedge clock);
        reset_n = 1'b1;

        chk("rst_ssid0", 64'(d_ssid[0]), 64'd0);
        chk("rst_sv0", 64'(d_sv[0]), 64'd0);
        chk("rst_ready", 64'(viol_ready_out), 64'd1);
        chk("rst_clear", 64'(clear_pulse_out), 64'd0);
        lookup(64'h1000, id, v);
        chk("cold_v", 64'(v), 64'd0);
        chk("cold_id", 64'(id), 64'd0);

        avoid_clear(120);
        report(64'h1000, 64'h2000);
        expect_lk("first_ld", 64'h1000, 1'b1, 7'd0);
        expect_lk("first_st", 64'h2000, 1'b1, 7'd0);
        report(64'h110, 64'h120);
        expect_lk("second", 64'h110, 1'b1, 7'd1);
        report(64'h200, 64'h204);
        report(64'h300, 64'h304);
        report(64'h400, 64'h404);
        report(64'h500, 64'h504);
        expect_lk("a_pre", 64'h500, 1'b1, 7'd5);
        expect_lk("b_pre", 64'h300, 1'b1, 7'd3);
        report(64'h500, 64'h300);
        expect_lk("a_merge", 64'h500, 1'b1, 7'd3);
        expect_lk("b_merge", 64'h300, 1'b1, 7'd3);
        report(64'h600, 64'h300);
        expect_lk("c_join", 64'h600, 1'b1, 7'd3);
        report(64'h700, 64'h704);
        expect_lk("alloc_kept", 64'h700, 1'b1, 7'd6);

        // Report whose write lands on the clear cycle
        n = 0;
        while (!(m_per == P - 3 && viol_ready_out) && n < 2 * P) begin
            @(negedge clock);
            n++;
        end
        ld_pc = 64'h800;
        st_pc = 64'h804;
        viol_valid = 1'b1;
        @(negedge clock);
        viol_valid = 1'b0;
        @(negedge clock);
        chk("clr_pulse_hi", 64'(clear_pulse_out), 64'd1);
        @(negedge clock);
        chk("clr_pulse_lo", 64'(clear_pulse_out), 64'd0);
        chk("clr_ready", 64'(viol_ready_out), 64'd1);
        expect_lk("clr_dropped", 64'h800, 1'b0, 7'd0);
        expect_lk("clr_wiped", 64'h500, 1'b0, 7'd0);

        // Drive the allocator to its last value and wrap
        for (int i = 0; i < 120; i++) begin
            avoid_clear(20);
            report(64'((600 + 2 * i) << 2), 64'((601 + 2 * i) << 2));
        end
        avoid_clear(40);
        report(64'(900 << 2), 64'(901 << 2));
        expect_lk("alloc_127", 64'(900 << 2), 1'b1, 7'd127);
        report(64'(902 << 2), 64'(903 << 2));
        expect_lk("alloc_wrap", 64'(902 << 2), 1'b1, 7'd0);

        // Stall holds the output registers
        stall_in = 1'b1;
        pcs[0] = 64'(900 << 2);
        lvs[0] = 1'b0;
        repeat (3) @(negedge clock);
        chk("stall_id", 64'(d_ssid[0]), 64'd0);
        chk("stall_v", 64'(d_sv[0]), 64'd1);
        stall_in = 1'b0;
        @(negedge clock);
        chk("unstall_id", 64'(d_ssid[0]), 64'd127);
        chk("unstall_v", 64'(d_sv[0]), 64'd0);

        // 0x1004 shares 0x0004's entry only without hashing
        avoid_clear(40);
        report(64'h0004, 64'h0008);
        lookup(64'h1004, id, v);
`ifdef SSIT_PC_HASH_EN
        chk("hash_split", 64'(v), 64'd0);
`else
        chk("hash_alias", 64'(v), 64'd1);
`endif

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            stall_in = ($urandom_range(4) == 0);
            for (int s = 0; s < 4; s++) begin
                pcs[s] = 64'(($urandom_range(3) << 12) |
                             ($urandom_range(15) << 2) | $urandom_range(3));
                lvs[s] = $urandom_range(1) == 1;
            end
            viol_valid = $urandom_range(1) == 1;
            ld_pc = 64'(($urandom_range(3) << 12) | ($urandom_range(15) << 2));
            st_pc = 64'(($urandom_range(3) << 12) | ($urandom_range(15) << 2));
            if (c == 2001) begin
                #2 reset_n = 1'b0;
                @(negedge clock);
                @(negedge clock);
                reset_n = 1'b1;
            end else begin
                @(negedge clock);
            end
        end
        viol_valid = 1'b0;
        repeat (4) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
